// File: rtl/bsg_fpu_normalize_denormal.sv
// Two-stage valid/ready normaliser: turns denormal operands into a hidden-bit
// mantissa plus widened signed exponent so downstream sees only normals.
module bsg_fpu_normalize_denormal #(
  parameter int e_p = 15,
  parameter int m_p = 112
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 v_i,
  output logic                 ready_o,
  input  logic                 sign_i,
  input  logic [e_p-1:0]       exp_i,
  input  logic [m_p-1:0]       man_i,
  input  logic                 zero_i,
  input  logic                 denormal_i,
  input  logic                 infty_i,
  input  logic                 nan_i,
  input  logic                 sig_nan_i,
  output logic                 v_o,
  input  logic                 yumi_i,
  output logic                 sign_o,
  output logic [e_p+1:0]       exp_o,
  output logic [m_p-1:0]       man_o,
  output logic                 zero_o,
  output logic                 infty_o,
  output logic                 nan_o,
  output logic                 sig_nan_o,
  output logic                 denormal_o
);

  localparam int unsigned lzc_w_p  = $clog2(m_p);
  localparam int unsigned exp_w_lp = e_p + 2;
  localparam int unsigned sh_w_lp  = lzc_w_p + 1;

  logic                r_s1_v;
  logic                r_s1_sign;
  logic [e_p-1:0]      r_s1_exp;
  logic [m_p-1:0]      r_s1_man;
  logic                r_s1_zero, r_s1_den, r_s1_inf, r_s1_nan, r_s1_snan;
  logic [lzc_w_p-1:0]  r_s1_lz;

  logic                r_s2_v;
  logic                r_s2_sign;
  logic [e_p+1:0]      r_s2_exp;
  logic [m_p-1:0]      r_s2_man;
  logic                r_s2_zero, r_s2_den, r_s2_inf, r_s2_nan, r_s2_snan;

  logic                w_s2_en;
  logic                w_s1_en;
  logic [lzc_w_p-1:0]  w_lz;
  logic [sh_w_lp-1:0]  w_shamt;
  logic [e_p+1:0]      w_exp;
  logic [m_p-1:0]      w_man;

  // Stage 2 moves when empty or retiring; stage 1 moves when empty or stage 2 moves.
  assign w_s2_en = ~r_s2_v | yumi_i;
  assign w_s1_en = ~r_s1_v | w_s2_en;
  assign ready_o = w_s1_en;

  // Leading-zero count, MSB first; the highest set bit wins.
  always_comb begin
    w_lz = '0;
    if (denormal_i) begin
      for (int i = 0; i < m_p; i++) begin
        if (man_i[i]) w_lz = lzc_w_p'(m_p - 1 - i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_s1_v    <= 1'b0;
      r_s1_sign <= 1'b0;
      r_s1_exp  <= '0;
      r_s1_man  <= '0;
      r_s1_zero <= 1'b0;
      r_s1_den  <= 1'b0;
      r_s1_inf  <= 1'b0;
      r_s1_nan  <= 1'b0;
      r_s1_snan <= 1'b0;
      r_s1_lz   <= '0;
    end else if (w_s1_en) begin
      r_s1_v <= v_i;
      if (v_i) begin
        r_s1_sign <= sign_i;
        r_s1_exp  <= exp_i;
        r_s1_man  <= man_i;
        r_s1_zero <= zero_i;
        r_s1_den  <= denormal_i;
        r_s1_inf  <= infty_i;
        r_s1_nan  <= nan_i;
        r_s1_snan <= sig_nan_i;
        r_s1_lz   <= w_lz;
      end
    end
  end

  // Class-dependent exponent/mantissa; denormals shift past their leading one.
  always_comb begin
    w_exp   = '0;
    w_man   = '0;
    w_shamt = sh_w_lp'(r_s1_lz) + sh_w_lp'(1);
    if (r_s1_zero) begin
      w_exp = '0;
      w_man = '0;
    end else if (r_s1_den) begin
      w_man = r_s1_man << w_shamt;
      w_exp = -exp_w_lp'(r_s1_lz);
    end else if (r_s1_inf | r_s1_nan | r_s1_snan) begin
      w_exp = exp_w_lp'({e_p{1'b1}});
      w_man = r_s1_man;
    end else begin
      w_exp = exp_w_lp'(r_s1_exp);
      w_man = r_s1_man;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_s2_v    <= 1'b0;
      r_s2_sign <= 1'b0;
      r_s2_exp  <= '0;
      r_s2_man  <= '0;
      r_s2_zero <= 1'b0;
      r_s2_den  <= 1'b0;
      r_s2_inf  <= 1'b0;
      r_s2_nan  <= 1'b0;
      r_s2_snan <= 1'b0;
    end else if (w_s2_en) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_sign <= r_s1_sign;
        r_s2_exp  <= w_exp;
        r_s2_man  <= w_man;
        r_s2_zero <= r_s1_zero;
        r_s2_den  <= r_s1_den;
        r_s2_inf  <= r_s1_inf;
        r_s2_nan  <= r_s1_nan;
        r_s2_snan <= r_s1_snan;
      end
    end
  end

  assign v_o        = r_s2_v;
  assign sign_o     = r_s2_sign;
  assign exp_o      = r_s2_exp;
  assign man_o      = r_s2_man;
  assign zero_o     = r_s2_zero;
  assign denormal_o = r_s2_den;
  assign infty_o    = r_s2_inf;
  assign nan_o      = r_s2_nan;
  assign sig_nan_o  = r_s2_snan;

endmodule
